// File: rtl/disp_frame_capture.sv
// Display-port capture: decodes command/data words, tracks a column/page window
// and stores RGB565 pixels in an internal framebuffer readable by the GUI.
module disp_frame_capture #(
  parameter int WIDTH    = 320,
  parameter int HEIGHT   = 240,
  parameter int PIX_BITS = 16,
  parameter int ADDR_W   = 17
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                disp_en,
  input  logic                disp_DC,
  input  logic [31:0]         disp_bus,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [PIX_BITS-1:0] rd_data,
  output logic                frame_done,
  output logic [31:0]         pix_count,
  output logic [15:0]         frame_count
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam logic [15:0] X_MAX = 16'(WIDTH - 1);
  localparam logic [15:0] Y_MAX = 16'(HEIGHT - 1);

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  typedef enum logic [1:0] {IDLE, CASET_ARG, PASET_ARG, RAMWR} state_t;

  state_t state, state_nxt;

  logic [15:0] xs, xe, ys, ye;
  logic [15:0] x, y;

  logic pix_we, caset_we, paset_we, cmd_swreset, cmd_ramwr, wrap;
  logic [ADDR_W-1:0] pix_addr;

  logic                wr_vld_p0;
  logic [ADDR_W-1:0]   wr_addr_p0;
  logic [PIX_BITS-1:0] wr_data_p0;

  logic [PIX_BITS-1:0] fb [0:NPIX-1];

  // Returns {end, start}: both limited to max, end never below start.
  function automatic logic [31:0] clamp_window(input logic [15:0] s_in,
                                               input logic [15:0] e_in,
                                               input logic [15:0] max_v);
    logic [15:0] s_c, e_c;
    s_c = (s_in > max_v) ? max_v : s_in;
    e_c = (e_in > max_v) ? max_v : e_in;
    if (s_c > e_c) e_c = s_c;
    return {e_c, s_c};
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (disp_en) begin
      if (!disp_DC) begin
        case (disp_bus[7:0])
          CMD_CASET: state_nxt = CASET_ARG;
          CMD_PASET: state_nxt = PASET_ARG;
          CMD_RAMWR: state_nxt = RAMWR;
          default:   state_nxt = IDLE;
        endcase
      end else if (state == CASET_ARG || state == PASET_ARG) begin
        state_nxt = IDLE;
      end
    end
  end

  always_comb begin
    pix_we      = disp_en && disp_DC && (state == RAMWR);
    caset_we    = disp_en && disp_DC && (state == CASET_ARG);
    paset_we    = disp_en && disp_DC && (state == PASET_ARG);
    cmd_swreset = disp_en && !disp_DC && (disp_bus[7:0] == CMD_SWRESET);
    cmd_ramwr   = disp_en && !disp_DC && (disp_bus[7:0] == CMD_RAMWR);
    wrap        = pix_we && (x >= xe) && (y >= ye);
    pix_addr    = ADDR_W'(32'(y) * 32'(WIDTH) + 32'(x));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      xs          <= '0;
      xe          <= X_MAX;
      ys          <= '0;
      ye          <= Y_MAX;
      x           <= '0;
      y           <= '0;
      frame_done  <= 1'b0;
      pix_count   <= '0;
      frame_count <= '0;
      wr_vld_p0   <= 1'b0;
    end else begin
      frame_done <= wrap;
      wr_vld_p0  <= pix_we;
      if (cmd_swreset) begin
        xs <= '0;
        xe <= X_MAX;
        ys <= '0;
        ye <= Y_MAX;
        x  <= '0;
        y  <= '0;
      end
      if (cmd_ramwr) begin
        x <= xs;
        y <= ys;
      end
      if (caset_we) {xe, xs} <= clamp_window(disp_bus[15:0], disp_bus[31:16], X_MAX);
      if (paset_we) {ye, ys} <= clamp_window(disp_bus[15:0], disp_bus[31:16], Y_MAX);
      if (pix_we) begin
        pix_count <= sat_inc32(pix_count);
        if (x < xe) begin
          x <= x + 16'd1;
        end else begin
          x <= xs;
          y <= (y < ye) ? y + 16'd1 : ys;
        end
      end
      if (wrap) frame_count <= frame_count + 16'd1;
    end
  end

  // Stage p0: registered write port
  always_ff @(posedge clk) begin
    if (pix_we) begin
      wr_addr_p0 <= pix_addr;
      wr_data_p0 <= disp_bus[PIX_BITS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_vld_p0) fb[wr_addr_p0] <= wr_data_p0;
  end

  always_ff @(posedge clk) begin
    if (reset)                            rd_data <= '0;
    else if (rd_addr < ADDR_W'(NPIX))     rd_data <= fb[rd_addr];
    else                                  rd_data <= '0;
  end

endmodule

// File: tb/tb_disp_frame_capture.sv
// Directed bench for disp_frame_capture: full frame, windowed writes, clamping,
// command abort and reset mid-frame.
module tb_disp_frame_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic        disp_en;
  logic        disp_DC;
  logic [31:0] disp_bus;
  logic [16:0] rd_addr;
  logic [15:0] rd_data;
  logic        frame_done;
  logic [31:0] pix_count;
  logic [15:0] frame_count;

  int n_checks = 0;
  int n_errors = 0;
  int fd_cnt   = 0;
  int fd_base;

  disp_frame_capture dut (
    .clk(clk), .reset(reset), .disp_en(disp_en), .disp_DC(disp_DC),
    .disp_bus(disp_bus), .rd_addr(rd_addr), .rd_data(rd_data),
    .frame_done(frame_done), .pix_count(pix_count), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_done) fd_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_word(input logic dc, input logic [31:0] w);
    disp_en  = 1'b1;
    disp_DC  = dc;
    disp_bus = w;
    @(negedge clk);
    disp_en  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  task automatic check_px(input string tag, input int a, input logic [15:0] exp);
    rd_addr = 17'(a);
    @(negedge clk);
    check_eq(tag, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    reset = 1'b0; disp_en = 1'b0; disp_DC = 1'b0; disp_bus = '0; rd_addr = '0;
    @(negedge clk);
    do_reset();
    check_eq("rst_pix_count", pix_count, 32'd0);
    check_eq("rst_frame_count", 32'(frame_count), 32'd0);
    check_eq("rst_frame_done", 32'(frame_done), 32'd0);
    check_eq("rst_rd_data", 32'(rd_data), 32'd0);

    // Test 1: full screen frame
    fd_base = fd_cnt;
    send_word(1'b0, 32'h2C);
    for (int i = 0; i < 76800; i++) begin
      send_word(1'b1, 32'(i[15:0]));
      if (i == 76798) check_eq("t1_fd_before_last", 32'(frame_done), 32'd0);
    end
    check_eq("t1_fd_after_last", 32'(frame_done), 32'd1);
    idle(1);
    check_eq("t1_fd_one_cycle", 32'(frame_done), 32'd0);
    idle(1);
    check_eq("t1_fd_pulses", 32'(fd_cnt - fd_base), 32'd1);
    check_eq("t1_frame_count", 32'(frame_count), 32'd1);
    check_eq("t1_pix_count", pix_count, 32'd76800);
    check_px("t1_fb319", 319, 16'h013F);
    check_px("t1_fb320", 320, 16'h0140);
    check_px("t1_fb_last", 76799, 16'h2BFF);
    check_px("t1_oob_76800", 76800, 16'h0000);
    check_px("t1_oob_max", 131071, 16'h0000);

    // Test 2: 4x2 window at (16,32); also read-during-write on the first pixel
    send_word(1'b0, 32'h2A);
    send_word(1'b1, 32'h0013_0010);
    send_word(1'b0, 32'h2B);
    send_word(1'b1, 32'h0021_0020);
    send_word(1'b0, 32'h2C);
    rd_addr = 17'(32 * 320 + 16);
    for (int i = 0; i < 8; i++) begin
      send_word(1'b1, 32'hA0 + 32'(i));
      if (i == 1) check_eq("t2_same_cycle_old", 32'(rd_data), 32'h2810);
      if (i == 2) check_eq("t2_visible_2cyc", 32'(rd_data), 32'h00A0);
      if (i == 6) check_eq("t2_fd_before_8th", 32'(frame_done), 32'd0);
    end
    check_eq("t2_fd_after_8th", 32'(frame_done), 32'd1);
    idle(1);
    check_eq("t2_frame_count", 32'(frame_count), 32'd2);
    for (int i = 0; i < 4; i++) begin
      check_px("t2_row32", 32 * 320 + 16 + i, 16'hA0 + 16'(i));
      check_px("t2_row33", 33 * 320 + 16 + i, 16'hA4 + 16'(i));
    end
    check_px("t2_row32_outside", 32 * 320 + 20, 16'h2814);

    // Test 3: start > end collapses to single column 9
    send_word(1'b0, 32'h2A);
    send_word(1'b1, 32'h0005_0009);
    send_word(1'b0, 32'h2C);
    send_word(1'b1, 32'h00B0);
    send_word(1'b1, 32'h00B1);
    check_eq("t3_fd_wrap", 32'(frame_done), 32'd1);
    idle(1);
    check_px("t3_col9_y32", 32 * 320 + 9, 16'h00B0);
    check_px("t3_col9_y33", 33 * 320 + 9, 16'h00B1);
    check_px("t3_col10_y32", 32 * 320 + 10, 16'h280A);
    check_eq("t3_frame_count", 32'(frame_count), 32'd3);

    // Test 4: end column clamped to 319
    send_word(1'b0, 32'h2A);
    send_word(1'b1, 32'hFFFF_0000);
    send_word(1'b0, 32'h2C);
    for (int i = 0; i < 320; i++) send_word(1'b1, 32'hC000 + 32'(i));
    check_eq("t4_no_fd", 32'(frame_done), 32'd0);
    idle(1);
    check_px("t4_row_first", 32 * 320, 16'hC000);
    check_px("t4_row_last", 32 * 320 + 319, 16'hC13F);
    check_px("t4_next_row", 33 * 320, 16'h2940);
    check_eq("t4_pix_count", pix_count, 32'd77130);

    // Test 5: argument word after PASET is not a pixel
    do_reset();
    send_word(1'b0, 32'h2C);
    send_word(1'b1, 32'h00D0);
    send_word(1'b1, 32'h00D1);
    send_word(1'b1, 32'h00D2);
    send_word(1'b0, 32'h2B);
    send_word(1'b1, 32'h0000_0000);
    idle(2);
    check_eq("t5_pix_count", pix_count, 32'd3);
    check_px("t5_fb0", 0, 16'h00D0);
    check_px("t5_fb2", 2, 16'h00D2);
    check_px("t5_fb3_untouched", 3, 16'h0003);

    // Test 6: reset in the middle of a frame
    do_reset();
    fd_base = fd_cnt;
    send_word(1'b0, 32'h2C);
    for (int i = 0; i < 100; i++) send_word(1'b1, 32'hE000 + 32'(i));
    do_reset();
    check_eq("t6_pix_count_rst", pix_count, 32'd0);
    check_eq("t6_frame_count_rst", 32'(frame_count), 32'd0);
    send_word(1'b1, 32'h1234);
    idle(1);
    check_eq("t6_idle_discard", pix_count, 32'd0);
    check_eq("t6_no_fd", 32'(fd_cnt - fd_base), 32'd0);
    send_word(1'b0, 32'h2C);
    send_word(1'b1, 32'h00F0);
    idle(2);
    check_px("t6_restart_00", 0, 16'h00F0);
    check_px("t6_kept_1", 1, 16'hE001);
    check_px("t6_kept_99", 99, 16'hE063);
    check_px("t6_fb100_old", 100, 16'h0064);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
